// File: rtl/daq_file_reader_pkg.sv
// rtl/daq_file_reader_pkg.sv - shared DAQ circular-file constants, field encodings and reader states
package daq_file_reader_pkg;

  localparam logic [31:0] WB_RAM0 = 32'h0000_8000;

  localparam logic [31:0] OFS_START   = 32'h00;
  localparam logic [31:0] OFS_END     = 32'h04;
  localparam logic [31:0] OFS_RD_PTR  = 32'h08;
  localparam logic [31:0] OFS_WR_PTR  = 32'h0C;
  localparam logic [31:0] OFS_STATUS  = 32'h10;
  localparam logic [31:0] OFS_CONTROL = 32'h14;

  localparam int F_STATUS_EMPTY       = 0;
  localparam int F_STATUS_FULL        = 1;
  localparam int F_STATUS_WRAP_AROUND = 2;
  localparam int F_STATUS_UNDERFLOW   = 3;

  localparam int F_CONTROL_DATA_SIZE = 0;
  localparam int W_CONTROL_DATA_SIZE = 2;

  localparam logic [1:0] B_CONTROL_DATA_SIZE_UNDEFINED = 2'd0;
  localparam logic [1:0] B_CONTROL_DATA_SIZE_BYTE      = 2'd1;
  localparam logic [1:0] B_CONTROL_DATA_SIZE_HWORD     = 2'd2;
  localparam logic [1:0] B_CONTROL_DATA_SIZE_WORD      = 2'd3;

  // Each bus state is immediately followed by its _DONE state in this ordering.
  typedef enum logic [4:0] {
    S_IDLE,
    S_RD_START,   S_RD_START_DONE,
    S_RD_END,     S_RD_END_DONE,
    S_RD_RDPTR,   S_RD_RDPTR_DONE,
    S_RD_WRPTR,   S_RD_WRPTR_DONE,
    S_RD_STATUS,  S_RD_STATUS_DONE,
    S_RD_CONTROL, S_RD_CONTROL_DONE,
    S_CHECK,
    S_RD_DATA,    S_RD_DATA_DONE,
    S_UPDATE,
    S_WR_STATUS,  S_WR_STATUS_DONE,
    S_WR_RDPTR,   S_WR_RDPTR_DONE,
    S_DONE
  } state_t;

  function automatic logic [2:0] size_incr(input logic [1:0] size);
    case (size)
      B_CONTROL_DATA_SIZE_WORD:  size_incr = 3'd4;
      B_CONTROL_DATA_SIZE_HWORD: size_incr = 3'd2;
      B_CONTROL_DATA_SIZE_BYTE:  size_incr = 3'd1;
      default:                   size_incr = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/daq_file_reader_lane_extract.sv
// rtl/daq_file_reader_lane_extract.sv - selects the byte/halfword/word lane of a bus word, zero-extended
module daq_file_reader_lane_extract
  import daq_file_reader_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  output logic [31:0] sample
);

  always_comb begin
    sample = '0;
    case (size)
      B_CONTROL_DATA_SIZE_WORD:  sample = word;
      B_CONTROL_DATA_SIZE_HWORD: sample = offset[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
      B_CONTROL_DATA_SIZE_BYTE: begin
        case (offset)
          2'd0:    sample = {24'd0, word[7:0]};
          2'd1:    sample = {24'd0, word[15:8]};
          2'd2:    sample = {24'd0, word[23:16]};
          default: sample = {24'd0, word[31:24]};
        endcase
      end
      default:   sample = '0;
    endcase
  end

endmodule

// File: rtl/daq_file_reader.sv
// rtl/daq_file_reader.sv - DAQ circular-file reader: descriptor walk, sample fetch, pointer write-back
// Optional descriptor cache enabled by defining DAQ_READER_DESC_CACHE_EN.
module daq_file_reader
  import daq_file_reader_pkg::*;
#(
  parameter int dw    = 32,
  parameter int aw    = 32,
  parameter int DEBUG = 0
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [7:0]    file_num,
  input  logic          file_read,
  output logic [31:0]   file_read_data,
  output logic          file_read_valid,
  output logic          file_read_err,
  output logic          file_active,
  output logic [aw-1:0] address,
  output logic          start,
  output logic [3:0]    selection,
  output logic          write,
  output logic [dw-1:0] data_wr,
  input  logic [dw-1:0] data_rd,
  input  logic          active
);

  if (DEBUG != 0) begin : g_debug
  end

  state_t      state;
  logic [7:0]  file_q;
  logic [31:0] start_addr, end_addr, rd_ptr, wr_ptr, status_q, rd_ptr_next_q, sample_q;
  logic [1:0]  control_q;
  logic        underflow_q, use_cache, cache_hit;

  logic [31:0] rdata, base_addr, req_addr, req_wdata;
  logic        req_write, req_state;
  logic [2:0]  incr;
  logic [31:0] rd_ptr_inc, rd_ptr_wrap, lane_sample;
  logic        empty;

  assign rdata       = data_rd[31:0];
  assign base_addr   = WB_RAM0 + {19'd0, file_q, 5'd0};
  assign incr        = size_incr(control_q);
  assign empty       = (rd_ptr == wr_ptr) && !status_q[F_STATUS_FULL];
  assign rd_ptr_inc  = rd_ptr + {29'd0, incr};
  assign rd_ptr_wrap = (rd_ptr_inc > end_addr) ? start_addr : rd_ptr_inc;

  daq_file_reader_lane_extract u_lane (
    .word   (rdata),
    .offset (rd_ptr[1:0]),
    .size   (control_q),
    .sample (lane_sample)
  );

`ifdef DAQ_READER_DESC_CACHE_EN
  logic       cache_valid;
  logic [7:0] cache_file;

  // START/END/CONTROL are only trusted after a complete descriptor walk for that file.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cache_valid <= 1'b0;
      cache_file  <= '0;
    end else if (state == S_RD_CONTROL_DONE && !active) begin
      cache_valid <= 1'b1;
      cache_file  <= file_q;
    end
  end

  assign cache_hit = cache_valid && (cache_file == file_num);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_state = 1'b1;
    case (state)
      S_RD_START:   req_addr = base_addr + OFS_START;
      S_RD_END:     req_addr = base_addr + OFS_END;
      S_RD_RDPTR:   req_addr = base_addr + OFS_RD_PTR;
      S_RD_WRPTR:   req_addr = base_addr + OFS_WR_PTR;
      S_RD_STATUS:  req_addr = base_addr + OFS_STATUS;
      S_RD_CONTROL: req_addr = base_addr + OFS_CONTROL;
      S_RD_DATA:    req_addr = {rd_ptr[31:2], 2'b00};
      S_WR_STATUS: begin
        req_addr  = base_addr + OFS_STATUS;
        req_write = 1'b1;
        req_wdata = status_q;
      end
      S_WR_RDPTR: begin
        req_addr  = base_addr + OFS_RD_PTR;
        req_write = 1'b1;
        req_wdata = rd_ptr_next_q;
      end
      default:      req_state = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state           <= S_IDLE;
      file_q          <= '0;
      start_addr      <= '0;
      end_addr        <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      status_q        <= '0;
      control_q       <= '0;
      rd_ptr_next_q   <= '0;
      sample_q        <= '0;
      underflow_q     <= 1'b0;
      use_cache       <= 1'b0;
      file_read_data  <= '0;
      file_read_valid <= 1'b0;
      file_read_err   <= 1'b0;
      file_active     <= 1'b0;
      address         <= '0;
      start           <= 1'b0;
      selection       <= '0;
      write           <= 1'b0;
      data_wr         <= '0;
    end else begin
      file_read_valid <= 1'b0;
      if (req_state) begin
        // Hold the request until the arbiter grants it, then drop start for the _DONE wait.
        if (active) begin
          start <= 1'b0;
          write <= 1'b0;
          state <= state_t'(state + 5'd1);
        end else begin
          start     <= 1'b1;
          address   <= req_addr[aw-1:0];
          selection <= 4'hF;
          write     <= req_write;
          data_wr   <= req_wdata;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (file_read) begin
              file_q         <= file_num;
              file_active    <= 1'b1;
              file_read_data <= '0;
              file_read_err  <= 1'b0;
              sample_q       <= '0;
              underflow_q    <= 1'b0;
              use_cache      <= cache_hit;
              state          <= cache_hit ? S_RD_RDPTR : S_RD_START;
            end
          end
          S_RD_START_DONE:   if (!active) begin start_addr <= rdata; state <= S_RD_END; end
          S_RD_END_DONE:     if (!active) begin end_addr <= rdata; state <= S_RD_RDPTR; end
          S_RD_RDPTR_DONE:   if (!active) begin rd_ptr <= rdata; state <= S_RD_WRPTR; end
          S_RD_WRPTR_DONE:   if (!active) begin wr_ptr <= rdata; state <= S_RD_STATUS; end
          S_RD_STATUS_DONE: begin
            if (!active) begin
              status_q <= rdata;
              state    <= use_cache ? S_CHECK : S_RD_CONTROL;
            end
          end
          S_RD_CONTROL_DONE: begin
            if (!active) begin
              control_q <= rdata[F_CONTROL_DATA_SIZE +: W_CONTROL_DATA_SIZE];
              state     <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (incr == 3'd0) begin
              file_read_valid <= 1'b1;
              file_read_err   <= 1'b1;
              file_read_data  <= sample_q;
              file_active     <= 1'b0;
              state           <= S_DONE;
            end else if (empty) begin
              status_q[F_STATUS_UNDERFLOW] <= 1'b1;
              underflow_q                  <= 1'b1;
              state                        <= S_WR_STATUS;
            end else begin
              state <= S_RD_DATA;
            end
          end
          S_RD_DATA_DONE:    if (!active) begin sample_q <= lane_sample; state <= S_UPDATE; end
          S_UPDATE: begin
            rd_ptr_next_q              <= rd_ptr_wrap;
            status_q[F_STATUS_FULL]    <= 1'b0;
            status_q[F_STATUS_EMPTY]   <= (rd_ptr_wrap == wr_ptr);
            state                      <= S_WR_STATUS;
          end
          S_WR_STATUS_DONE: begin
            if (!active) begin
              if (underflow_q) begin
                file_read_valid <= 1'b1;
                file_read_err   <= 1'b1;
                file_read_data  <= '0;
                file_active     <= 1'b0;
                state           <= S_DONE;
              end else begin
                state <= S_WR_RDPTR;
              end
            end
          end
          S_WR_RDPTR_DONE: begin
            if (!active) begin
              file_read_valid <= 1'b1;
              file_read_err   <= 1'b0;
              file_read_data  <= sample_q;
              file_active     <= 1'b0;
              state           <= S_DONE;
            end
          end
          S_DONE: begin
            address   <= '0;
            selection <= '0;
            data_wr   <= '0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daq_file_reader.sv
// tb/tb_daq_file_reader.sv - directed self-checking bench for daq_file_reader with a RAM/bus model
module tb_daq_file_reader;
  import daq_file_reader_pkg::*;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [7:0]  file_num = '0;
  logic        file_read = 1'b0;
  logic [31:0] file_read_data;
  logic        file_read_valid, file_read_err, file_active;
  logic [31:0] address;
  logic        start;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic [31:0] data_rd = '0;
  logic        active = 1'b0;

  int checks = 0;
  int failures = 0;
  int bus_count = 0;
  int valid_count = 0;
  int hold = 0;
  logic [31:0] mem [logic [31:0]];

  daq_file_reader #(.dw(32), .aw(32), .DEBUG(0)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .file_num(file_num), .file_read(file_read),
    .file_read_data(file_read_data), .file_read_valid(file_read_valid),
    .file_read_err(file_read_err), .file_active(file_active),
    .address(address), .start(start), .selection(selection), .write(write),
    .data_wr(data_wr), .data_rd(data_rd), .active(active)
  );

  always #5 wb_clk = ~wb_clk;

  // RAM slave: grants on the falling edge, keeps active high for two falling edges.
  always @(negedge wb_clk) begin
    if (wb_rst) begin
      active = 1'b0;
      hold = 0;
    end else if (active) begin
      if (hold == 0) active = 1'b0;
      else hold = hold - 1;
    end else if (start) begin
      bus_count = bus_count + 1;
      if (write) mem[address] = data_wr;
      else data_rd = mem.exists(address) ? mem[address] : 32'd0;
      active = 1'b1;
      hold = 1;
    end
  end

  always @(negedge wb_clk) if (file_read_valid) valid_count = valid_count + 1;

  function automatic logic [31:0] desc(input logic [7:0] f);
    return 32'h0000_8000 + 32'(f) * 32'd32;
  endfunction

  task automatic set_desc(input logic [7:0] f, input logic [31:0] s, e, rp, wp, st, ct);
    logic [31:0] b;
    b = desc(f);
    mem[b] = s; mem[b + 4] = e; mem[b + 8] = rp;
    mem[b + 12] = wp; mem[b + 16] = st; mem[b + 20] = ct;
  endtask

  task automatic do_read(input logic [7:0] f, input int repulse, output logic [31:0] d,
                         output logic e, output int nbus, output int nvalid, output logic act);
    int b0, v0;
    bit got;
    b0 = bus_count; v0 = valid_count; got = 0; d = '0; e = 1'b0;
    @(negedge wb_clk); file_num = f; file_read = 1'b1;
    @(negedge wb_clk); file_read = 1'b0; act = file_active;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge wb_clk);
      file_read = (i == repulse);
      if (file_read_valid) begin
        got = 1; d = file_read_data; e = file_read_err;
      end
    end
    file_read = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL read_timeout file=%0d: no file_read_valid within 400 cycles", f);
    end
    repeat (6) @(negedge wb_clk);
    nbus = bus_count - b0;
    nvalid = valid_count - v0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge wb_clk);
    checks++;
    if ({file_read_data, file_read_valid, file_read_err, file_active} !== 35'd0) begin
      failures++;
      $display("FAIL reset_file_outputs got=%h want=0", {file_read_data, file_read_valid, file_read_err, file_active});
    end
    checks++;
    if ({address, start, selection, write, data_wr} !== 70'd0) begin
      failures++;
      $display("FAIL reset_bus_outputs got=%h want=0", {address, start, selection, write, data_wr});
    end
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic test_word;
    logic [31:0] d; logic e, act; int nb, nv;
    set_desc(2, 32'h1000, 32'h10FC, 32'h1000, 32'h1008, 32'h0, 32'(B_CONTROL_DATA_SIZE_WORD));
    mem[32'h1000] = 32'hDEADBEEF;
    do_read(2, -1, d, e, nb, nv, act);
    checks++; if (act !== 1'b1) begin failures++; $display("FAIL word_active got=%b want=1", act); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL word_data got=%h want=deadbeef", d); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL word_err got=%b want=0", e); end
    checks++; if (mem[desc(2) + 8] !== 32'h1004) begin failures++; $display("FAIL word_rdptr got=%h want=00001004", mem[desc(2) + 8]); end
    checks++; if (mem[desc(2) + 16] !== 32'h0) begin failures++; $display("FAIL word_status got=%h want=0", mem[desc(2) + 16]); end
    checks++; if (nb !== 9) begin failures++; $display("FAIL word_bus_count got=%0d want=9", nb); end
    checks++; if (file_active !== 1'b0 || start !== 1'b0 || address !== 32'd0) begin
      failures++; $display("FAIL word_idle_outputs active=%b start=%b addr=%h want 0", file_active, start, address);
    end
  endtask

  task automatic test_byte;
    logic [31:0] d; logic e, act; int nb, nv;
    set_desc(3, 32'h1000, 32'h10FC, 32'h1003, 32'h1010, 32'h0, 32'(B_CONTROL_DATA_SIZE_BYTE));
    mem[32'h1000] = 32'hA1B2C3D4;
    do_read(3, -1, d, e, nb, nv, act);
    checks++; if (d !== 32'h000000A1) begin failures++; $display("FAIL byte_data got=%h want=000000a1", d); end
    checks++; if (mem[desc(3) + 8] !== 32'h1004) begin failures++; $display("FAIL byte_rdptr got=%h want=00001004", mem[desc(3) + 8]); end
  endtask

  task automatic test_hword_wrap;
    logic [31:0] d; logic e, act; int nb, nv;
    set_desc(4, 32'h1000, 32'h10FC, 32'h10FE, 32'h1010, 32'h4, 32'(B_CONTROL_DATA_SIZE_HWORD));
    mem[32'h10FC] = 32'h55667788;
    do_read(4, -1, d, e, nb, nv, act);
    checks++; if (d !== 32'h00005566) begin failures++; $display("FAIL hword_data got=%h want=00005566", d); end
    checks++; if (mem[desc(4) + 8] !== 32'h1000) begin failures++; $display("FAIL hword_wrap_rdptr got=%h want=00001000", mem[desc(4) + 8]); end
    checks++; if (mem[desc(4) + 16] !== 32'h4) begin failures++; $display("FAIL hword_status got=%h want=00000004", mem[desc(4) + 16]); end
  endtask

  task automatic test_underflow;
    logic [31:0] d; logic e, act; int nb, nv;
    set_desc(5, 32'h1000, 32'h10FC, 32'h1040, 32'h1040, 32'h0, 32'(B_CONTROL_DATA_SIZE_WORD));
    mem[32'h1040] = 32'h12345678;
    do_read(5, -1, d, e, nb, nv, act);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b want=1", e); end
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL underflow_data got=%h want=0", d); end
    checks++; if (mem[desc(5) + 16] !== 32'h8) begin failures++; $display("FAIL underflow_status got=%h want=00000008", mem[desc(5) + 16]); end
    checks++; if (mem[desc(5) + 8] !== 32'h1040) begin failures++; $display("FAIL underflow_rdptr got=%h want=00001040", mem[desc(5) + 8]); end
    checks++; if (nb !== 7) begin failures++; $display("FAIL underflow_bus_count got=%0d want=7", nb); end
  endtask

  task automatic test_last_sample_back_to_back;
    logic [31:0] d; logic e, act; int nb, nv;
    set_desc(6, 32'h1000, 32'h10FC, 32'h1004, 32'h1008, 32'h2, 32'(B_CONTROL_DATA_SIZE_WORD));
    mem[32'h1004] = 32'h13579BDF;
    do_read(6, 6, d, e, nb, nv, act);
    checks++; if (d !== 32'h13579BDF) begin failures++; $display("FAIL last_data got=%h want=13579bdf", d); end
    checks++; if (mem[desc(6) + 16] !== 32'h1) begin failures++; $display("FAIL last_status got=%h want=00000001", mem[desc(6) + 16]); end
    checks++; if (mem[desc(6) + 8] !== 32'h1008) begin failures++; $display("FAIL last_rdptr got=%h want=00001008", mem[desc(6) + 8]); end
    checks++; if (nv !== 1) begin failures++; $display("FAIL ignored_request_valids got=%0d want=1", nv); end
    checks++; if (nb !== 9) begin failures++; $display("FAIL ignored_request_bus got=%0d want=9", nb); end
  endtask

  task automatic test_undefined_size;
    logic [31:0] d; logic e, act; int nb, nv;
    set_desc(7, 32'h1000, 32'h10FC, 32'h1000, 32'h1008, 32'h0, 32'(B_CONTROL_DATA_SIZE_UNDEFINED));
    do_read(7, -1, d, e, nb, nv, act);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL undef_err got=%b want=1", e); end
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL undef_data got=%h want=0", d); end
    checks++; if (nb !== 6) begin failures++; $display("FAIL undef_bus_count got=%0d want=6", nb); end
  endtask

  task automatic test_reset_mid;
    bit hit;
    set_desc(8, 32'h1000, 32'h10FC, 32'h1000, 32'h1008, 32'h0, 32'(B_CONTROL_DATA_SIZE_WORD));
    hit = 0;
    @(negedge wb_clk); file_num = 8'd8; file_read = 1'b1;
    @(negedge wb_clk); file_read = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge wb_clk); #1;
      if (start && address == 32'h1000) hit = 1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL reset_mid_timeout: RD_DATA request never seen"); end
    wb_rst = 1'b1;
    #1;
    checks++;
    if ({file_read_data, file_read_valid, file_read_err, file_active, address, start, selection, write, data_wr} !== 105'd0) begin
      failures++; $display("FAIL reset_mid_outputs start=%b active=%b addr=%h want all 0", start, file_active, address);
    end
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (4) @(negedge wb_clk);
    checks++;
    if (mem[desc(8) + 8] !== 32'h1000 || start !== 1'b0) begin
      failures++; $display("FAIL reset_mid_no_writeback rdptr=%h start=%b want 00001000/0", mem[desc(8) + 8], start);
    end
  endtask

  task automatic test_desc_cache;
    logic [31:0] d; logic e, act; int nb, nv, want;
    set_desc(9, 32'h2000, 32'h20FC, 32'h2000, 32'h2010, 32'h0, 32'(B_CONTROL_DATA_SIZE_WORD));
    mem[32'h2000] = 32'hCAFE0001;
    mem[32'h2004] = 32'hCAFE0002;
    do_read(9, -1, d, e, nb, nv, act);
    checks++; if (nb !== 9) begin failures++; $display("FAIL cache_first_bus got=%0d want=9", nb); end
    do_read(9, -1, d, e, nb, nv, act);
`ifdef DAQ_READER_DESC_CACHE_EN
    want = 6;
`else
    want = 9;
`endif
    checks++; if (nb !== want) begin failures++; $display("FAIL cache_repeat_bus got=%0d want=%0d", nb, want); end
    checks++; if (d !== 32'hCAFE0002) begin failures++; $display("FAIL cache_repeat_data got=%h want=cafe0002", d); end
    checks++; if (mem[desc(9) + 8] !== 32'h2008) begin failures++; $display("FAIL cache_repeat_rdptr got=%h want=00002008", mem[desc(9) + 8]); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_hword_wrap;
    test_underflow;
    test_last_sample_back_to_back;
    test_undefined_size;
    test_reset_mid;
    test_desc_cache;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
